// File: rtl/debug_cmd_player.sv
// debug_cmd_player: replays a loaded table of debug command frames
// onto the pipeline debug input, with hold, gap and optional wait-for-ack.
module debug_cmd_player #(
  parameter int NB_CONTROL_FRAME = 32,
  parameter int N_ENTRIES        = 64,
  parameter int NB_IDX           = $clog2(N_ENTRIES),
  parameter int NB_HOLD          = 4,
  parameter int NB_TIMEOUT       = 16,
  parameter logic [NB_CONTROL_FRAME-1:0] IDLE_FRAME = 32'h2800_0000
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_load_we,
  input  logic [NB_IDX-1:0]           i_load_addr,
  input  logic [NB_CONTROL_FRAME-1:0] i_load_frame,
  input  logic [NB_HOLD-1:0]          i_load_hold,
  input  logic [NB_HOLD-1:0]          i_load_gap,
  input  logic                        i_load_wait,
  input  logic [NB_IDX:0]             i_num_entries,
  input  logic                        i_loop,
  input  logic [NB_TIMEOUT-1:0]       i_timeout,
  input  logic                        i_start,
  input  logic                        i_stop,
  input  logic                        i_ack,
  input  logic [NB_CONTROL_FRAME-1:0] i_frame_to_blaze,
  output logic [NB_CONTROL_FRAME-1:0] o_frame_from_blaze,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_timeout,
  output logic [NB_IDX-1:0]           o_entry_idx,
  output logic [NB_CONTROL_FRAME-1:0] o_resp_data,
  output logic                        o_resp_valid
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_WAIT,
    ST_GAP
  } state_t;

  localparam logic [NB_HOLD-1:0]    HOLD_ONE = {{(NB_HOLD-1){1'b0}}, 1'b1};
  localparam logic [NB_TIMEOUT-1:0] TMO_ONE  = {{(NB_TIMEOUT-1){1'b0}}, 1'b1};
  localparam logic [NB_IDX:0]       IDX_ONE  = {{NB_IDX{1'b0}}, 1'b1};

  logic [NB_CONTROL_FRAME-1:0] r_tab_frame [N_ENTRIES];
  logic [NB_HOLD-1:0]          r_tab_hold  [N_ENTRIES];
  logic [NB_HOLD-1:0]          r_tab_gap   [N_ENTRIES];
  logic                        r_tab_wait  [N_ENTRIES];

  state_t                      r_state;
  logic [NB_IDX-1:0]           r_idx;
  logic [NB_HOLD-1:0]          r_cnt;
  logic [NB_TIMEOUT-1:0]       r_tcnt;
  logic [NB_IDX:0]             r_num;
  logic                        r_loop;
  logic [NB_CONTROL_FRAME-1:0] r_frame;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_timeout;
  logic [NB_CONTROL_FRAME-1:0] r_resp_data;
  logic                        r_resp_valid;

  state_t                      w_state_nx;
  logic [NB_IDX-1:0]           w_idx_nx;
  logic [NB_HOLD-1:0]          w_cnt_nx;
  logic [NB_TIMEOUT-1:0]       w_tcnt_nx;
  logic [NB_IDX:0]             w_num_nx;
  logic                        w_loop_nx;
  logic [NB_CONTROL_FRAME-1:0] w_frame_nx;
  logic                        w_busy_nx;
  logic                        w_done_nx;
  logic                        w_timeout_nx;
  logic [NB_CONTROL_FRAME-1:0] w_resp_data_nx;
  logic                        w_resp_valid_nx;
  logic                        w_go_next;

  logic [NB_IDX:0]             w_idx_p1;
  logic                        w_last;
  logic [NB_IDX-1:0]           w_nidx;
  logic [NB_HOLD-1:0]          w_cur_hold;
  logic [NB_HOLD-1:0]          w_cur_gap;
  logic                        w_cur_wait;
  logic [NB_CONTROL_FRAME-1:0] w_nxt_frame;
  logic [NB_HOLD-1:0]          w_nxt_hold;

  // Table write port; the table is only writable while idle.
  always_ff @(posedge i_clock) begin
    if (i_load_we && r_state == ST_IDLE) begin
      r_tab_frame[i_load_addr] <= i_load_frame;
      r_tab_hold[i_load_addr]  <= i_load_hold;
      r_tab_gap[i_load_addr]   <= i_load_gap;
      r_tab_wait[i_load_addr]  <= i_load_wait;
    end
  end

  assign w_idx_p1    = {1'b0, r_idx} + IDX_ONE;
  assign w_last      = (w_idx_p1 >= r_num);
  assign w_nidx      = w_last ? '0 : w_idx_p1[NB_IDX-1:0];
  assign w_cur_hold  = r_tab_hold[r_idx];
  assign w_cur_gap   = r_tab_gap[r_idx];
  assign w_cur_wait  = r_tab_wait[r_idx];
  assign w_nxt_frame = r_tab_frame[w_nidx];
  assign w_nxt_hold  = r_tab_hold[w_nidx];

  // Next-state and next-output logic for the playback FSM.
  always_comb begin
    w_state_nx      = r_state;
    w_idx_nx        = r_idx;
    w_cnt_nx        = r_cnt;
    w_tcnt_nx       = r_tcnt;
    w_num_nx        = r_num;
    w_loop_nx       = r_loop;
    w_frame_nx      = r_frame;
    w_busy_nx       = r_busy;
    w_done_nx       = 1'b0;
    w_timeout_nx    = r_timeout;
    w_resp_data_nx  = r_resp_data;
    w_resp_valid_nx = 1'b0;
    w_go_next       = 1'b0;
    if (i_stop) begin
      w_state_nx = ST_IDLE;
      w_busy_nx  = 1'b0;
      w_frame_nx = IDLE_FRAME;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (i_num_entries != '0) begin
              w_state_nx   = ST_HOLD;
              w_num_nx     = i_num_entries;
              w_loop_nx    = i_loop;
              w_idx_nx     = '0;
              w_timeout_nx = 1'b0;
              w_busy_nx    = 1'b1;
              w_frame_nx   = r_tab_frame[0];
              w_cnt_nx     = r_tab_hold[0];
            end else begin
              w_done_nx = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (r_cnt != '0) begin
            w_cnt_nx = r_cnt - HOLD_ONE;
          end else if (w_cur_wait) begin
            w_state_nx = ST_WAIT;
            w_frame_nx = IDLE_FRAME;
            w_tcnt_nx  = TMO_ONE;
          end else if (w_cur_gap != '0) begin
            w_state_nx = ST_GAP;
            w_frame_nx = IDLE_FRAME;
            w_cnt_nx   = w_cur_gap;
          end else begin
            w_go_next = 1'b1;
          end
        end
        ST_WAIT: begin
          if (i_ack) begin
            w_resp_data_nx  = i_frame_to_blaze;
            w_resp_valid_nx = 1'b1;
            if (w_cur_gap != '0) begin
              w_state_nx = ST_GAP;
              w_cnt_nx   = w_cur_gap;
            end else begin
              w_go_next = 1'b1;
            end
          end else if (i_timeout != '0 && r_tcnt == i_timeout) begin
            w_state_nx   = ST_IDLE;
            w_busy_nx    = 1'b0;
            w_done_nx    = 1'b1;
            w_timeout_nx = 1'b1;
            w_frame_nx   = IDLE_FRAME;
          end else begin
            w_tcnt_nx = r_tcnt + TMO_ONE;
          end
        end
        ST_GAP: begin
          if (r_cnt <= HOLD_ONE) begin
            w_go_next = 1'b1;
          end else begin
            w_cnt_nx = r_cnt - HOLD_ONE;
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_busy_nx  = 1'b0;
          w_frame_nx = IDLE_FRAME;
        end
      endcase
      // Entry finished: advance without an idle cycle, wrap, or finish.
      if (w_go_next) begin
        if (!w_last || r_loop) begin
          w_state_nx = ST_HOLD;
          w_idx_nx   = w_nidx;
          w_frame_nx = w_nxt_frame;
          w_cnt_nx   = w_nxt_hold;
        end else begin
          w_state_nx = ST_IDLE;
          w_busy_nx  = 1'b0;
          w_done_nx  = 1'b1;
          w_frame_nx = IDLE_FRAME;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_tcnt       <= '0;
      r_num        <= '0;
      r_loop       <= 1'b0;
      r_frame      <= IDLE_FRAME;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_resp_data  <= '0;
      r_resp_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_idx        <= w_idx_nx;
      r_cnt        <= w_cnt_nx;
      r_tcnt       <= w_tcnt_nx;
      r_num        <= w_num_nx;
      r_loop       <= w_loop_nx;
      r_frame      <= w_frame_nx;
      r_busy       <= w_busy_nx;
      r_done       <= w_done_nx;
      r_timeout    <= w_timeout_nx;
      r_resp_data  <= w_resp_data_nx;
      r_resp_valid <= w_resp_valid_nx;
    end
  end

  assign o_frame_from_blaze = r_frame;
  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_timeout          = r_timeout;
  assign o_entry_idx        = r_idx;
  assign o_resp_data        = r_resp_data;
  assign o_resp_valid       = r_resp_valid;

endmodule

// File: tb/tb_debug_cmd_player.sv
// tb_debug_cmd_player: directed self-checking bench for
// debug_cmd_player with hand-computed frame sequences.
module tb_debug_cmd_player;

  localparam logic [31:0] IDLE = 32'h2800_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_we;
  logic [5:0]  load_addr;
  logic [31:0] load_frame;
  logic [3:0]  load_hold;
  logic [3:0]  load_gap;
  logic        load_wait;
  logic [6:0]  num;
  logic        loop_en;
  logic [15:0] tmo;
  logic        start;
  logic        stop;
  logic        ack;
  logic [31:0] to_blaze;
  logic [31:0] frame;
  logic        busy;
  logic        done;
  logic        tflag;
  logic [5:0]  idx;
  logic [31:0] rdata;
  logic        rvalid;

  int n_chk  = 0;
  int n_fail = 0;

  debug_cmd_player dut (
    .i_clock            (clk),
    .i_reset            (rst),
    .i_load_we          (load_we),
    .i_load_addr        (load_addr),
    .i_load_frame       (load_frame),
    .i_load_hold        (load_hold),
    .i_load_gap         (load_gap),
    .i_load_wait        (load_wait),
    .i_num_entries      (num),
    .i_loop             (loop_en),
    .i_timeout          (tmo),
    .i_start            (start),
    .i_stop             (stop),
    .i_ack              (ack),
    .i_frame_to_blaze   (to_blaze),
    .o_frame_from_blaze (frame),
    .o_busy             (busy),
    .o_done             (done),
    .o_timeout          (tflag),
    .o_entry_idx        (idx),
    .o_resp_data        (rdata),
    .o_resp_valid       (rvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] a, input logic [31:0] f,
                      input logic [3:0] h, input logic [3:0] g,
                      input logic w);
    load_we    = 1'b1;
    load_addr  = a;
    load_frame = f;
    load_hold  = h;
    load_gap   = g;
    load_wait  = w;
    tick();
    load_we = 1'b0;
  endtask

  task automatic go(input logic [6:0] n, input logic lp);
    num     = n;
    loop_en = lp;
    start   = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [31:0] seq1 [9];

  initial begin
    rst = 1'b1; load_we = 0; load_addr = 0; load_frame = 0;
    load_hold = 0; load_gap = 0; load_wait = 0; num = 0;
    loop_en = 0; tmo = 0; start = 0; stop = 0; ack = 0;
    to_blaze = 0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_frame", frame, IDLE);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_tmo", {31'b0, tflag}, 0);
    chk("rst_idx", {26'b0, idx}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rvalid", {31'b0, rvalid}, 0);

    // three-entry sequence with gaps
    load(0, 32'h0800_0000, 1, 1, 0);
    load(1, 32'h2040_0000, 1, 2, 0);
    load(2, 32'h0400_0000, 1, 0, 0);
    seq1 = '{32'h0800_0000, 32'h0800_0000, IDLE,
             32'h2040_0000, 32'h2040_0000, IDLE, IDLE,
             32'h0400_0000, 32'h0400_0000};
    go(3, 0);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("seq1_f%0d", k), frame, seq1[k]);
      chk($sformatf("seq1_b%0d", k), {31'b0, busy}, 1);
      chk($sformatf("seq1_d%0d", k), {31'b0, done}, 0);
      tick();
    end
    chk("seq1_done", {31'b0, done}, 1);
    chk("seq1_busy_end", {31'b0, busy}, 0);
    chk("seq1_idle", frame, IDLE);
    tick();
    chk("seq1_done_pulse", {31'b0, done}, 0);

    // wait-for-ack with response capture
    load(0, 32'h0C00_8000, 0, 0, 1);
    tmo = 10;
    go(1, 0);
    chk("ack_hold", frame, 32'h0C00_8000);
    tick();
    chk("ack_wait_frame", frame, IDLE);
    tick(); tick(); tick();
    chk("ack_no_early", {31'b0, rvalid}, 0);
    ack = 1'b1;
    to_blaze = 32'hDEAD_BEEF;
    tick();
    ack = 1'b0;
    chk("ack_rvalid", {31'b0, rvalid}, 1);
    chk("ack_rdata", rdata, 32'hDEAD_BEEF);
    chk("ack_done", {31'b0, done}, 1);
    chk("ack_busy", {31'b0, busy}, 0);
    chk("ack_tmo", {31'b0, tflag}, 0);
    ack = 1'b1;
    to_blaze = 32'h1234_5678;
    tick();
    ack = 1'b0;
    chk("ack_idle_rvalid", {31'b0, rvalid}, 0);
    chk("ack_idle_rdata", rdata, 32'hDEAD_BEEF);

    // timeout after five wait cycles
    tmo = 5;
    go(1, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("tmo_wait%0d", k), frame, IDLE);
      chk($sformatf("tmo_busy%0d", k), {31'b0, busy}, 1);
      chk($sformatf("tmo_flag%0d", k), {31'b0, tflag}, 0);
      tick();
    end
    chk("tmo_set", {31'b0, tflag}, 1);
    chk("tmo_done", {31'b0, done}, 1);
    chk("tmo_busy_end", {31'b0, busy}, 0);
    tick();
    chk("tmo_sticky", {31'b0, tflag}, 1);
    chk("tmo_done_pulse", {31'b0, done}, 0);
    tmo = 10;
    go(1, 0);
    chk("tmo_clear", {31'b0, tflag}, 0);
    chk("tmo_restart", frame, 32'h0C00_8000);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_wait_busy", {31'b0, busy}, 0);
    chk("stop_wait_done", {31'b0, done}, 0);

    // looping two entries, stray acks ignored, then stop
    load(0, 32'h0800_0000, 0, 0, 0);
    load(1, 32'h2040_0000, 0, 0, 0);
    ack = 1'b1;
    go(2, 1);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("loop_f%0d", k), frame,
          (k % 2) ? 32'h2040_0000 : 32'h0800_0000);
      chk($sformatf("loop_i%0d", k), {26'b0, idx}, k % 2);
      chk($sformatf("loop_rv%0d", k), {31'b0, rvalid}, 0);
      tick();
    end
    ack = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("loop_stop_frame", frame, IDLE);
    chk("loop_stop_busy", {31'b0, busy}, 0);
    chk("loop_stop_done", {31'b0, done}, 0);
    chk("loop_rdata", rdata, 32'hDEAD_BEEF);
    tick();
    chk("loop_stop_done2", {31'b0, done}, 0);

    // zero entries
    go(0, 0);
    chk("zero_done", {31'b0, done}, 1);
    chk("zero_busy", {31'b0, busy}, 0);
    chk("zero_frame", frame, IDLE);
    tick();
    chk("zero_done_pulse", {31'b0, done}, 0);

    // load while busy is ignored
    load(0, 32'h1111_0000, 2, 0, 0);
    go(1, 0);
    chk("lwb_f0", frame, 32'h1111_0000);
    load(0, 32'h2222_0000, 0, 0, 0);
    chk("lwb_f1", frame, 32'h1111_0000);
    tick();
    chk("lwb_f2", frame, 32'h1111_0000);
    tick();
    chk("lwb_done", {31'b0, done}, 1);
    go(1, 0);
    chk("lwb_replay", frame, 32'h1111_0000);
    tick(); tick();
    chk("lwb_replay2", frame, 32'h1111_0000);
    tick();
    chk("lwb_done2", {31'b0, done}, 1);

    // reset in the middle of entry 1
    load(1, 32'h3333_0000, 2, 0, 0);
    go(2, 0);
    tick(); tick(); tick();
    chk("rmid_f", frame, 32'h3333_0000);
    chk("rmid_idx", {26'b0, idx}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmid_frame", frame, IDLE);
    chk("rmid_busy", {31'b0, busy}, 0);
    chk("rmid_idx0", {26'b0, idx}, 0);
    chk("rmid_rdata", rdata, 0);
    chk("rmid_done", {31'b0, done}, 0);
    tick();
    chk("rmid_stay", frame, IDLE);
    go(2, 0);
    chk("rmid_restart", frame, 32'h1111_0000);
    chk("rmid_restart_idx", {26'b0, idx}, 0);
    chk("rmid_restart_busy", {31'b0, busy}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_cmd_player.md
# debug_cmd_player

Programmable replay engine for debug-unit command frames, the synthesisable successor of the timer-indexed command stimulus used to exercise `pipeline`. A table of up to `N_ENTRIES` command frames, each with its own hold length, gap length and optional wait-for-acknowledge, is loaded through a write port. The table is then played onto the `i_frame_from_blaze` input of the pipeline's debug interface. The block sits between the host/MicroBlaze side and `pipeline`, and lets a test sequence run on hardware, optionally in a loop.

## Interface
- `NB_CONTROL_FRAME`, 32, width of a command/response frame ({code[6], valid[1], type[9], addr[16]}).
- `N_ENTRIES`, 64, table depth; power of two ≥ 2.
- `NB_IDX`, clog2(`N_ENTRIES`), entry index width.
- `NB_HOLD`, 4, width of the per-entry hold and gap counts.
- `NB_TIMEOUT`, 16, width of the wait-for-ack timeout counter.
- `IDLE_FRAME`, 32'h2800_0000, frame driven when no entry is active (code 6'b001010, valid 0).

Ports:
- `i_clock` in 1: single clock.
- `i_reset` in 1: synchronous, active-high.
- `i_load_we` in 1: write one table entry.
- `i_load_addr` in `NB_IDX`: entry written.
- `i_load_frame` in `NB_CONTROL_FRAME`: frame of entry.
- `i_load_hold` in `NB_HOLD`: entry frame driven for hold+1 cycles.
- `i_load_gap` in `NB_HOLD`: `IDLE_FRAME` cycles after the entry.
- `i_load_wait` in 1: wait for `i_ack` before the gap.
- `i_num_entries` in `NB_IDX`+1: entries to play (0..`N_ENTRIES`); sampled at start.
- `i_loop` in 1: restart at entry 0 after the last entry; sampled at start.
- `i_timeout` in `NB_TIMEOUT`: wait limit in cycles; 0 disables the timeout.
- `i_start` in 1: start pulse.
- `i_stop` in 1: abort.
- `i_ack` in 1: response-ready strobe from the debug side.
- `i_frame_to_blaze` in `NB_CONTROL_FRAME`: response frame from `pipeline`.
- `o_frame_from_blaze` out `NB_CONTROL_FRAME`: played frame (registered).
- `o_busy` out 1: playback active.
- `o_done` out 1: one-cycle pulse at normal completion or timeout abort.
- `o_timeout` out 1: sticky; cleared by reset or by an accepted start.
- `o_entry_idx` out `NB_IDX`: index of the current entry.
- `o_resp_data` out `NB_CONTROL_FRAME`: `i_frame_to_blaze` captured on an accepted ack.
- `o_resp_valid` out 1: one-cycle pulse with the capture.

## Operation
- Table entry fields: frame, hold, gap, wait. The table is not reset.
- Loads are accepted only in IDLE. A load while busy is ignored.
- All outputs are registered.

States and transitions:
- IDLE: drives `IDLE_FRAME`, `o_busy`=0.
  - `i_start` with num>0: latch num and loop, idx=0, clear `o_timeout`, go to HOLD.
  - `i_start` with num=0: pulse `o_done`, stay in IDLE.
- HOLD: drives entry[idx].frame for hold+1 cycles.
  - At expiry with wait=1: go to WAIT.
  - At expiry with wait=0 and gap>0: go to GAP.
  - At expiry with wait=0 and gap=0: go to NEXT.
- WAIT: drives `IDLE_FRAME`.
  - `i_ack`: capture `i_frame_to_blaze` into `o_resp_data`, pulse `o_resp_valid`, then go to GAP (gap>0) or NEXT (gap=0).
  - Counter reaching `i_timeout` (nonzero): set `o_timeout`, pulse `o_done`, go to IDLE.
  - `i_ack` on the same cycle as expiry: the ack wins.
- GAP: drives `IDLE_FRAME` for gap cycles, then NEXT.
- NEXT is a decision, not a cycle:
  - idx+1 < num: idx+1, load the next entry's HOLD in the same cycle.
  - Last entry and loop=1: idx=0, go to HOLD.
  - Last entry and loop=0: pulse `o_done`, go to IDLE.
- `i_stop`: IDLE on the next edge from any state, with no `o_done`. It has priority over ack, timeout and start.
- `i_start` while busy: ignored.
- `i_ack` outside WAIT: ignored, no capture.

## Timing
- Reset values:
  - `o_frame_from_blaze`=`IDLE_FRAME`.
  - `o_busy`, `o_done`, `o_timeout`, `o_resp_valid`=0.
  - `o_entry_idx`=0, `o_resp_data`=0.
  - State IDLE.
- Reset mid-playback behaves exactly like a reset from IDLE.
- Start latency: `i_start` sampled at edge t → entry 0 frame and `o_busy`=1 visible after edge t.
- Back-to-back entries (wait=0, gap=0): frames are contiguous, with no idle cycle between them.
- `o_done` is asserted on the same edge where `o_busy` falls.
- The timeout counter counts WAIT cycles starting at 1. Expiry happens on the cycle the count equals `i_timeout`.
- Frame count for an entry: hold+1 cycles, plus WAIT cycles, plus gap cycles.

## Test plan
- Load 3 entries (RESET 32'h0800_0000 h=1 g=1; MODE_GET 32'h2040_0000 h=1 g=2; START 32'h0400_0000 h=1 g=0), num=3, start → output sequence: 0800_0000 ×2, 2800_0000 ×1, 2040_0000 ×2, 2800_0000 ×2, 0400_0000 ×2; `o_done` pulses on the edge after the last START cycle.
- Entry 32'h0C00_8000 h=0 wait=1 g=0, timeout=10, `i_ack` 4 cycles into WAIT with `i_frame_to_blaze`=32'hDEAD_BEEF → `o_resp_valid` pulse, `o_resp_data`=DEAD_BEEF, then done.
- Same entry, no ack, timeout=5 → 5 WAIT cycles, `o_timeout`=1, `o_done` pulse; a new start clears `o_timeout`.
- num=2, loop=1, h=0 g=0 → frames alternate every cycle for 10 cycles; `i_stop` → `IDLE_FRAME` next cycle, `o_busy`=0, no `o_done`.
- num=0 start → `o_done` pulse only, output stays 2800_0000. A load while busy does not alter the replayed frames.
- `i_reset` asserted mid-HOLD → all outputs take their reset values on the next edge; `i_start` afterwards replays from entry 0.
